// File: rtl/instr_regfile_alu.sv
// Register file of ALU results: 1-cycle ops, OP_WIDTH+1 cycles for DIV/MOD; wr_ready low while busy.
// Define INSTR_REG_BYPASS_EN to forward the entry being written onto the read port.
module instr_regfile_alu #(
    parameter  int OP_WIDTH  = 32,
    parameter  int DEPTH     = 32,
    localparam int RES_WIDTH = 2 * OP_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [2:0]                 opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic [AW-1:0]              write_pointer,
    input  logic [AW-1:0]              read_pointer,
    output logic [2:0]                 rd_opcode,
    output logic [OP_WIDTH-1:0]        rd_operand_a,
    output logic [OP_WIDTH-1:0]        rd_operand_b,
    output logic [RES_WIDTH-1:0]       rd_result,
    output logic                       rd_valid,
    output logic                       rd_err,
    output logic                       wr_done,
    output logic [AW-1:0]              done_ptr
);
    localparam int CW = $clog2(OP_WIDTH + 1);
    localparam logic [2:0] OP_ZERO = 3'd0, OP_PASSA = 3'd1, OP_PASSB = 3'd2, OP_ADD = 3'd3,
                           OP_SUB  = 3'd4, OP_MULT  = 3'd5, OP_DIV   = 3'd6, OP_MOD = 3'd7;

    typedef enum logic [1:0] {IDLE, DIV_RUN, WRITE} state_t;
    state_t state, state_nxt;

    logic [2:0]           op_q;
    logic [OP_WIDTH-1:0]  a_q, b_q, quo_q, rem_q, dvs_q;
    logic [AW-1:0]        ptr_q;
    logic [RES_WIDTH-1:0] res_q;
    logic                 err_q;
    logic [CW-1:0]        cnt_q;

    logic [2:0]           ent_op  [DEPTH];
    logic [OP_WIDTH-1:0]  ent_a   [DEPTH];
    logic [OP_WIDTH-1:0]  ent_b   [DEPTH];
    logic [RES_WIDTH-1:0] ent_res [DEPTH];
    logic [DEPTH-1:0]     ent_vld, ent_err;

    logic                 accept, is_div_in, b_zero, rem_ge;
    logic [RES_WIDTH-1:0] a_ext, b_ext, alu_res, q_ext, r_ext, div_res, wr_res;
    logic [OP_WIDTH-1:0]  a_mag, b_mag, rem_dif, rem_nxt, quo_nxt;
    logic [OP_WIDTH:0]    rem_sh;

    assign wr_ready  = (state == IDLE);
    assign accept    = wr_valid && wr_ready;
    assign is_div_in = (opcode == OP_DIV) || (opcode == OP_MOD);
    assign b_zero    = (operand_b == '0);
    assign a_ext     = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    assign b_ext     = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
    assign a_mag     = operand_a[OP_WIDTH-1] ? -operand_a : operand_a;
    assign b_mag     = operand_b[OP_WIDTH-1] ? -operand_b : operand_b;

    // Sign-extended operands keep the low RES_WIDTH bits of the product exact.
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            default:  alu_res = '0;
        endcase
    end

    // Restoring divide on magnitudes; signs are applied once the quotient is complete.
    assign rem_sh  = {rem_q, quo_q[OP_WIDTH-1]};
    assign rem_ge  = (rem_sh >= {1'b0, dvs_q});
    assign rem_dif = rem_sh[OP_WIDTH-1:0] - dvs_q;
    assign rem_nxt = rem_ge ? rem_dif : rem_sh[OP_WIDTH-1:0];
    assign quo_nxt = {quo_q[OP_WIDTH-2:0], rem_ge};

    assign q_ext   = {{OP_WIDTH{1'b0}}, quo_q};
    assign r_ext   = {{OP_WIDTH{1'b0}}, rem_q};
    assign div_res = (op_q == OP_DIV) ? ((a_q[OP_WIDTH-1] ^ b_q[OP_WIDTH-1]) ? -q_ext : q_ext)
                                      : (a_q[OP_WIDTH-1] ? -r_ext : r_ext);
    assign wr_res  = ((op_q == OP_DIV || op_q == OP_MOD) && !err_q) ? div_res : res_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (is_div_in && !b_zero) ? DIV_RUN : WRITE;
            DIV_RUN: if (cnt_q == CW'(OP_WIDTH - 1)) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ptr_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            wr_done  <= 1'b0;
            done_ptr <= '0;
        end else begin
            state   <= state_nxt;
            wr_done <= (state == WRITE);
            if (state == WRITE) done_ptr <= ptr_q;
            if (accept) begin
                op_q  <= opcode;
                a_q   <= operand_a;
                b_q   <= operand_b;
                ptr_q <= write_pointer;
                res_q <= is_div_in ? '0 : alu_res;
                err_q <= is_div_in && b_zero;
                quo_q <= a_mag;
                rem_q <= '0;
                dvs_q <= b_mag;
                cnt_q <= '0;
            end else if (state == DIV_RUN) begin
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_vld <= '0;
            ent_err <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_op[i]  <= '0;
                ent_a[i]   <= '0;
                ent_b[i]   <= '0;
                ent_res[i] <= '0;
            end
        end else if (state == WRITE) begin
            ent_op[ptr_q]  <= op_q;
            ent_a[ptr_q]   <= a_q;
            ent_b[ptr_q]   <= b_q;
            ent_res[ptr_q] <= wr_res;
            ent_vld[ptr_q] <= 1'b1;
            ent_err[ptr_q] <= err_q;
        end
    end

    always_comb begin
        rd_opcode    = ent_op[read_pointer];
        rd_operand_a = ent_a[read_pointer];
        rd_operand_b = ent_b[read_pointer];
        rd_result    = ent_res[read_pointer];
        rd_valid     = ent_vld[read_pointer];
        rd_err       = ent_err[read_pointer];
`ifdef INSTR_REG_BYPASS_EN
        if (state == WRITE && read_pointer == ptr_q) begin
            rd_opcode    = op_q;
            rd_operand_a = a_q;
            rd_operand_b = b_q;
            rd_result    = wr_res;
            rd_valid     = 1'b1;
            rd_err       = err_q;
        end
`endif
    end
endmodule

// File: doc/instr_regfile_alu.md
INSTR_REGFILE_ALU -- requirements
Module: instr_regfile_alu

Interface
REQ-001 Parameter OP_WIDTH, default 32: signed operand width in bits; legal range 4 to 64.
REQ-002 Parameter DEPTH, default 32: number of register entries; power of two, minimum 2.
REQ-003 Parameter RES_WIDTH, derived as 2*OP_WIDTH: signed result width in bits; not user-overridable.
REQ-004 Parameter AW, derived as $clog2(DEPTH): width of the write and read pointers.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port wr_valid, input, 1: a write request is presented this cycle.
REQ-008 Port wr_ready, output, 1: the block accepts a request this cycle.
REQ-009 Port opcode, input, 3: operation select; ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-010 Ports operand_a and operand_b, input, OP_WIDTH, signed: the two source operands.
REQ-011 Port write_pointer, input, AW: destination entry for the request.
REQ-012 Port read_pointer, input, AW: entry to read.
REQ-013 Port rd_opcode, output, 3: opcode field of the entry at read_pointer.
REQ-014 Ports rd_operand_a and rd_operand_b, output, OP_WIDTH: operand fields of the entry at read_pointer.
REQ-015 Port rd_result, output, RES_WIDTH: result field of the entry at read_pointer.
REQ-016 Port rd_valid, output, 1: the entry at read_pointer has been written since reset.
REQ-017 Port rd_err, output, 1: the entry at read_pointer holds a divide-by-zero result.
REQ-018 Port wr_done, output, 1: one-cycle pulse marking an entry write.
REQ-019 Port done_ptr, output, AW: the entry written when wr_done is high.

Function
REQ-020 A request SHALL be accepted on any rising edge where both wr_valid and wr_ready are high; at acceptance, opcode, operand_a, operand_b and write_pointer SHALL be captured.
REQ-021 The FSM SHALL have three states: IDLE, DIV_RUN and WRITE; wr_ready SHALL be high only in IDLE.
REQ-022 An accepted non-divide opcode SHALL cause IDLE->WRITE; the entry write SHALL occur on the next edge, giving a latency of 1 cycle.
REQ-023 An accepted DIV or MOD with a nonzero divisor SHALL cause IDLE->DIV_RUN.
REQ-024 The divider SHALL be iterative, radix-2, one quotient bit per cycle, and run for OP_WIDTH cycles, then go to WRITE; total latency SHALL be OP_WIDTH+1 cycles.
REQ-025 DIV or MOD with operand_b==0 SHALL go directly to WRITE with result 0 and the err bit set; all other writes SHALL clear the entry's err bit.
REQ-026 Results SHALL be sign-extended to RES_WIDTH: ADD and SUB are exact, MULT is the full signed product, PASSA and PASSB are sign-extended, and ZERO gives 0.
REQ-027 DIV SHALL truncate toward zero; the MOD sign SHALL follow the dividend; the most-negative value divided by -1 SHALL return +2^(OP_WIDTH-1) with no wrap.
REQ-028 In WRITE, the block SHALL store {opcode, a, b, result, err}, set the entry's valid bit, pulse wr_done with done_ptr, and return to IDLE.
REQ-029 A rewrite of an already-valid entry SHALL overwrite it; write_pointer wrap-around is inherent in AW.
REQ-030 The read port SHALL be combinational from the array; a read of the entry being written on the same edge SHALL return the old contents unless REQ-036 applies.
REQ-031 wr_valid while wr_ready is low SHALL be ignored, and inputs are not sampled.

Reset
REQ-032 reset_n low SHALL immediately clear every entry, every valid and err bit, and the FSM to IDLE.
REQ-033 During reset, wr_done SHALL be 0, done_ptr 0, and wr_ready 1 once reset is released.
REQ-034 Reset asserted mid-DIV_RUN SHALL abort the division with no entry write and no wr_done.
REQ-035 After reset, all rd_* outputs SHALL read 0.

Configuration
REQ-036 With macro INSTR_REG_BYPASS_EN defined, a read whose read_pointer equals the entry being written in the WRITE state SHALL return the new contents, rd_valid=1 and the new err, in the same cycle; without the macro, REQ-030 applies.

Verification
REQ-037 Reset, then ADD a=5, b=3 to ptr 4: wr_done after 1 cycle, done_ptr=4, and read ptr 4 gives result 8, rd_valid=1, rd_err=0.
REQ-038 DIV a=-7, b=2 to ptr 1: wr_ready low for 33 cycles, result -3; MOD with the same operands to ptr 2 gives result -1.
REQ-039 DIV a=9, b=0 to ptr 3: result 0, rd_err=1 after 1 cycle; a subsequent PASSA a=1 to ptr 3 gives rd_err=0.
REQ-040 MULT a=-2^31, b=-2^31: result +2^62 with no truncation; DIV a=-2^31, b=-1 gives +2^31.
REQ-041 reset_n pulsed low at cycle 10 of a DIV: no wr_done, all rd_valid=0, wr_ready=1 after release.
REQ-042 With read_pointer equal to write_pointer=7 during WRITE: old data without INSTR_REG_BYPASS_EN, new data with it.
